pipeline_hazard_ctrl: RTL and testbench

Central stall, flush and forward controller for the 5-stage ARM pipeline. It sits beside ID_Stage and drives ID's `hazard` input. It also drives the IF freeze, the IF/ID and ID/EXE flush, and the EXE operand-forward selects, and it sequences a whole-pipe freeze while the SRAM data port is busy.

---
 rtl/arm_pkg.sv | 25 ++
 rtl/mem_wait_fsm.sv | 81 ++++++++
 rtl/pipeline_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline control blocks: register index width,
// EXE operand-forward mux encodings, memory-wait FSM states and a match helper.
package arm_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_e;

    // A source register depends on a stage when that stage writes it back.
    function automatic logic reg_match(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dest,
        input logic             wb_en
    );
        return wb_en && (src == dest);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-port wait sequencer: freezes the whole pipe while the SRAM data port
// is busy, counts wait cycles and raises a sticky timeout flag.
module mem_wait_fsm
    import arm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    input  logic clr_stats,
    output logic freeze_pipe,
    output logic mem_error
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_error_q, mem_error_d;
    logic          timeout;

    // The first busy cycle is frozen straight from the inputs, so a stall
    // costs no extra latency; a zero-wait access never freezes.
    always_comb begin
        freeze_pipe = (state_q == MS_IDLE) ? (mem_req & ~mem_ready) : ~mem_ready;
    end

    // Next state, wait counter and timeout flag; a timeout only flags, the
    // access keeps waiting. Clearing the stats wins over a coincident timeout.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        timeout     = (state_q == MS_WAIT) && (wait_cnt_q == CNT_LAST) && !mem_ready;
        case (state_q)
            MS_IDLE: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MS_WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            MS_WAIT: begin
                if (mem_ready) begin
                    state_d    = MS_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = MS_IDLE;
                wait_cnt_d = '0;
            end
        endcase
        if (clr_stats) begin
            mem_error_d = 1'b0;
        end else if (timeout) begin
            mem_error_d = 1'b1;
        end
    end

    // FSM state, counter and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MS_IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / forward controller for the 5-stage ARM pipeline. Produces
// the ID hazard bubble, IF freeze, branch flush, EXE forward selects and the
// whole-pipe freeze, and keeps a saturating stall-cycle statistic.
module pipeline_hazard_ctrl
    import arm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_src1,
    input  logic [REG_W-1:0] exe_src2,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_stats,
    output logic             hazard,
    output logic             freeze_if,
    output logic             flush,
    output logic             freeze_pipe,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    logic             exe_hit, mem_hit, raw_hazard;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .clr_stats  (clr_stats),
        .freeze_pipe(freeze_pipe),
        .mem_error  (mem_error)
    );

    // RAW detection: without forwarding any EXE/MEM producer stalls; with
    // forwarding only a load in EXE does, since its data is not ready yet.
    always_comb begin
        exe_hit = reg_match(id_src1, exe_dest, exe_wb_en) |
                  (id_two_src & reg_match(id_src2, exe_dest, exe_wb_en));
        mem_hit = reg_match(id_src1, mem_dest, mem_wb_en) |
                  (id_two_src & reg_match(id_src2, mem_dest, mem_wb_en));
        raw_hazard = fwd_en ? (exe_hit & exe_mem_r_en) : (exe_hit | mem_hit);
        // A frozen pipe holds branch_taken in EXE; masking flush then gives
        // exactly one flush, on the release cycle.
        hazard    = raw_hazard & ~branch_taken & ~freeze_pipe;
        freeze_if = hazard | freeze_pipe;
        flush     = branch_taken & ~freeze_pipe;
    end

    // Operand forwarding, youngest producer (MEM) first.
    always_comb begin
        sel_src1 = FWD_REG;
        sel_src2 = FWD_REG;
        if (fwd_en) begin
            if (reg_match(exe_src1, mem_dest, mem_wb_en))      sel_src1 = FWD_MEM;
            else if (reg_match(exe_src1, wb_dest, wb_wb_en))   sel_src1 = FWD_WB;
            if (reg_match(exe_src2, mem_dest, mem_wb_en))      sel_src2 = FWD_MEM;
            else if (reg_match(exe_src2, wb_dest, wb_wb_en))   sel_src2 = FWD_WB;
        end
    end

    // Saturating stall statistic; clear has priority over counting.
    always_comb begin
        stall_count_d = stall_count_q;
        if (clr_stats) begin
            stall_count_d = '0;
        end else if ((hazard | freeze_pipe) && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4. Inputs
// change on the falling edge; outputs are sampled 2ns later, before the next
// rising edge.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
    logic [3:0]  id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic        branch_taken, mem_req, mem_ready, clr_stats;
    logic        hazard, freeze_if, flush, freeze_pipe, mem_error;
    logic [1:0]  sel_src1, sel_src2;
    logic [15:0] stall_count;

    int n_vec = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .clr_stats(clr_stats),
        .hazard(hazard), .freeze_if(freeze_if), .flush(flush),
        .freeze_pipe(freeze_pipe), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_error(mem_error), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_inputs();
        fwd_en = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_wb_en = 0; wb_wb_en = 0; id_src1 = 0; id_src2 = 0;
        exe_src1 = 0; exe_src2 = 0; exe_dest = 0; mem_dest = 0; wb_dest = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; clr_stats = 0;
    endtask

    // advance to the next falling edge (input change point)
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        #12;
        chk("rst_hazard", 32'(hazard), 0);
        chk("rst_freeze_pipe", 32'(freeze_pipe), 0);
        chk("rst_mem_error", 32'(mem_error), 0);
        chk("rst_stall_count", 32'(stall_count), 0);
        chk("rst_sel1", 32'(sel_src1), 0);
        nxt(); rst = 1'b0;

        // no forwarding: EXE producer
        nxt(); id_src1 = 3; exe_dest = 3; exe_wb_en = 1; settle();
        chk("nofwd_exe_hazard", 32'(hazard), 1);
        chk("nofwd_exe_freeze_if", 32'(freeze_if), 1);
        nxt(); exe_wb_en = 0; settle();
        chk("nofwd_exe_nowb", 32'(hazard), 0);
        chk("nofwd_exe_nowb_fif", 32'(freeze_if), 0);
        // MEM producer stalls, WB does not
        nxt(); clr_inputs(); id_src1 = 7; mem_dest = 7; mem_wb_en = 1; settle();
        chk("nofwd_mem_hazard", 32'(hazard), 1);
        nxt(); mem_wb_en = 0; wb_dest = 7; wb_wb_en = 1; settle();
        chk("nofwd_wb_nohazard", 32'(hazard), 0);
        // src2 only counts when id_two_src
        nxt(); clr_inputs(); id_src1 = 1; id_src2 = 5; exe_dest = 5; exe_wb_en = 1; settle();
        chk("src2_ignored", 32'(hazard), 0);
        nxt(); id_two_src = 1; settle();
        chk("src2_used", 32'(hazard), 1);

        // forwarding: load-use only
        nxt(); fwd_en = 1; exe_mem_r_en = 1; settle();
        chk("fwd_loaduse", 32'(hazard), 1);
        nxt(); exe_mem_r_en = 0; settle();
        chk("fwd_alu_nohazard", 32'(hazard), 0);
        nxt(); clr_inputs(); fwd_en = 1; id_src1 = 6; mem_dest = 6; mem_wb_en = 1; settle();
        chk("fwd_mem_nohazard", 32'(hazard), 0);

        // forward selects
        nxt(); clr_inputs(); fwd_en = 1; exe_src1 = 2; mem_dest = 2; wb_dest = 2;
        mem_wb_en = 1; wb_wb_en = 1; settle();
        chk("sel1_mem_prio", 32'(sel_src1), 32'h1);
        nxt(); mem_wb_en = 0; settle();
        chk("sel1_wb", 32'(sel_src1), 32'h2);
        nxt(); wb_wb_en = 0; settle();
        chk("sel1_none", 32'(sel_src1), 32'h0);
        nxt(); mem_wb_en = 1; wb_wb_en = 1; fwd_en = 0; settle();
        chk("sel1_fwd_off", 32'(sel_src1), 32'h0);
        nxt(); fwd_en = 1; exe_src2 = 9; wb_dest = 9; settle();
        chk("sel1_mem_again", 32'(sel_src1), 32'h1);
        chk("sel2_wb", 32'(sel_src2), 32'h2);

        // branch masks hazard
        nxt(); clr_inputs(); id_src1 = 3; exe_dest = 3; exe_wb_en = 1; branch_taken = 1; settle();
        chk("br_flush", 32'(flush), 1);
        chk("br_hazard_masked", 32'(hazard), 0);
        chk("br_freeze_if", 32'(freeze_if), 0);

        // clear stats, then a 3-cycle memory wait
        nxt(); clr_inputs(); clr_stats = 1;
        nxt(); clr_stats = 0; settle();
        chk("clr_stall_count", 32'(stall_count), 0);
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) nxt();
            settle();
            chk($sformatf("wait_freeze_%0d", i), 32'(freeze_pipe), 1);
            chk($sformatf("wait_freeze_if_%0d", i), 32'(freeze_if), 1);
        end
        nxt(); mem_ready = 1; settle();
        chk("wait_release", 32'(freeze_pipe), 0);
        nxt(); mem_req = 0; mem_ready = 0; settle();
        chk("back_idle", 32'(freeze_pipe), 0);
        chk("stall_count_3", 32'(stall_count), 3);

        // zero-wait access
        nxt(); mem_req = 1; mem_ready = 1; settle();
        chk("zero_wait", 32'(freeze_pipe), 0);
        nxt(); mem_req = 0; mem_ready = 0; settle();
        chk("zero_wait_idle", 32'(freeze_pipe), 0);

        // branch held through a 2-cycle freeze, with a RAW hazard pending
        nxt(); id_src1 = 4; exe_dest = 4; exe_wb_en = 1; branch_taken = 1;
        mem_req = 1; mem_ready = 0; settle();
        chk("frz_flush0", 32'(flush), 0);
        chk("frz_hazard0", 32'(hazard), 0);
        nxt(); settle();
        chk("frz_flush1", 32'(flush), 0);
        nxt(); mem_ready = 1; settle();
        chk("frz_release_flush", 32'(flush), 1);
        chk("frz_release_hazard", 32'(hazard), 0);

        // timeout with MEM_TIMEOUT=4
        nxt(); clr_inputs(); mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            settle();
            chk($sformatf("to_err0_%0d", i), 32'(mem_error), 0);
        end
        nxt(); settle();
        chk("to_err_set", 32'(mem_error), 1);
        chk("to_still_frozen", 32'(freeze_pipe), 1);
        nxt(); settle();
        chk("to_err_sticky", 32'(mem_error), 1);
        clr_stats = 1;
        nxt(); clr_stats = 0; settle();
        chk("to_clr_err", 32'(mem_error), 0);
        chk("to_clr_stall", 32'(stall_count), 0);
        chk("to_wait_frozen", 32'(freeze_pipe), 1);

        // async reset mid-WAIT
        mem_req = 0; #1;
        chk("wait_freeze_noreq", 32'(freeze_pipe), 1);
        rst = 1'b1; #1;
        chk("arst_freeze", 32'(freeze_pipe), 0);
        chk("arst_stall", 32'(stall_count), 0);
        nxt(); rst = 1'b0;
        nxt(); settle();
        chk("post_rst_idle", 32'(freeze_pipe), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
